// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
//   PIX_W   : pixel / result width
//   KSIZE   : kernel edge length
//   WIN_N   : window element count
//   win_t   : packed 3x3 window, element 0 = A11 (top-left), row-major
//   state_t : frame sequencer states
//   win_shift : shift a window left one column and insert a new right column
package conv_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned KSIZE = 3;
    localparam int unsigned WIN_N = KSIZE * KSIZE;

    typedef logic [WIN_N-1:0][PIX_W-1:0] win_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // New right column is {top, mid, bot}; left column falls off.
    function automatic win_t win_shift(input win_t w,
                                       input logic [PIX_W-1:0] top,
                                       input logic [PIX_W-1:0] mid,
                                       input logic [PIX_W-1:0] bot);
        win_t n;
        n = w;
        for (int unsigned r = 0; r < KSIZE; r++) begin
            for (int unsigned c = 0; c < KSIZE - 1; c++) begin
                n[r*KSIZE + c] = w[r*KSIZE + c + 1];
            end
        end
        n[KSIZE-1]         = top;
        n[2*KSIZE-1]       = mid;
        n[KSIZE*KSIZE-1]   = bot;
        return n;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Bus bundle for conv_window_ctrl.
//   start_i/busy_o/done_o              : frame control
//   pix_valid_i/pix_ready_o/pix_data_i : raster pixel stream in
//   win_o/conv_b_i                     : window out to conv, result back
//   res_valid_o/res_ready_i/res_data_o : result stream out
// slave = the controller's view, master = the environment's view.
interface conv_window_ctrl_if;
    import conv_pkg::*;

    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic [PIX_W-1:0] pix_data_i;
    win_t             win_o;
    logic [PIX_W-1:0] conv_b_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [PIX_W-1:0] res_data_o;

    modport slave (
        input  start_i, pix_valid_i, pix_data_i, conv_b_i, res_ready_i,
        output busy_o, done_o, pix_ready_o, win_o, res_valid_o, res_data_o
    );

    modport master (
        output start_i, pix_valid_i, pix_data_i, conv_b_i, res_ready_i,
        input  busy_o, done_o, pix_ready_o, win_o, res_valid_o, res_data_o
    );

endinterface

// File: rtl/conv_window_ctrl_linebuf.sv
// Two-row line buffer for the window builder.
//   clk   : clock
//   addr  : shared column address
//   we    : write enable (one pixel accepted)
//   wdata : incoming pixel, written into row buffer 0
//   rd0   : lb0[addr], the previous row (combinational read)
//   rd1   : lb1[addr], two rows back (combinational read)
// On a write the old lb0 entry moves down into lb1, so both buffers advance
// by one row at the same column. Contents are not reset.
module conv_linebuf
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 28
) (
    input  logic                                 clk,
    input  logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] addr,
    input  logic                                 we,
    input  logic [PIX_W-1:0]                     wdata,
    output logic [PIX_W-1:0]                     rd0,
    output logic [PIX_W-1:0]                     rd1
);

    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];

    assign rd0 = lb0_q[addr];
    assign rd1 = lb1_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            lb1_q[addr] <= lb0_q[addr];
            lb0_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer feeding an external combinational 3x3 conv unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : conv_window_ctrl_if.slave (frame control, pixel stream,
//              window/conv result, registered result stream)
// Builds 3x3 windows from a raster pixel stream using two line buffers,
// registers the conv result and emits (IMG_W-2)*(IMG_H-2) results per frame.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_ctrl_if.slave   bus
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    win_t             win_q, win_d;
    logic             win_vld_q, win_vld_d;
    logic             res_valid_q, res_valid_d;
    logic [PIX_W-1:0] res_data_q, res_data_d;

    logic             adv;
    logic             pix_ready;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             res_hs;
    logic             frame_done;
    logic [PIX_W-1:0] lb_rd0;
    logic [PIX_W-1:0] lb_rd1;

    conv_linebuf #(
        .IMG_W (IMG_W)
    ) u_linebuf (
        .clk   (clk),
        .addr  (col_q),
        .we    (accept),
        .wdata (bus.pix_data_i),
        .rd0   (lb_rd0),
        .rd1   (lb_rd1)
    );

    // The window stage may advance when it is empty or its result can move
    // into the result slot this cycle (slot empty or being drained).
    assign adv        = !win_vld_q || !res_valid_q || bus.res_ready_i;
    assign pix_ready  = (state_q == RUN) && adv;
    assign accept     = bus.pix_valid_i && pix_ready;
    assign last_col   = (col_q == CW'(IMG_W - 1));
    assign last_row   = (row_q == RW'(IMG_H - 1));
    assign res_hs     = res_valid_q && bus.res_ready_i;
    assign frame_done = (state_q == FLUSH) && !win_vld_q && res_hs;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_vld_d   = win_vld_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept && last_col && last_row) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            win_d     = win_shift(win_q, lb_rd1, lb_rd0, bus.pix_data_i);
            // Windows straddling a row wrap or the top rows are junk.
            win_vld_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (adv) begin
            win_vld_d = 1'b0;
        end

        // Capture uses the current window, so a same-cycle pixel accept that
        // replaces the window is safe.
        if (win_vld_q && adv) begin
            res_data_d  = bus.conv_b_i;
            res_valid_d = 1'b1;
        end else if (bus.res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_vld_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_vld_q   <= win_vld_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = frame_done;
    assign bus.pix_ready_o = pix_ready;
    assign bus.win_o       = win_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on a 5x4 frame with a behavioural
// 3x3 conv unit (weighted sum plus bias, truncated to 8 bits).
module tb_conv_window_ctrl;
    import conv_pkg::*;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NRES = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_ctrl_if bus();

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // External conv unit
    logic [7:0] kern [9];
    logic [7:0] bias;
    always_comb begin
        int unsigned acc;
        acc = 32'(bias);
        for (int unsigned i = 0; i < 9; i++) acc += 32'(bus.win_o[i]) * 32'(kern[i]);
        bus.conv_b_i = acc[7:0];
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] img [NPIX];
    logic [7:0] res_q [$];
    logic [7:0] exp_q [$];
    int   done_cnt, acc22_cyc, first_res_cyc, stall_chg, pr_drop;
    logic busy_after, finished;
    win_t win22;
    int   rmode, vmode, abort_after, start_pulse_cyc;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Direct reference: each valid window is read straight out of the image.
    task automatic build_expected();
        int unsigned acc;
        exp_q.delete();
        for (int unsigned r = 2; r < H; r++) begin
            for (int unsigned c = 2; c < W; c++) begin
                acc = 32'(bias);
                for (int unsigned dr = 0; dr < 3; dr++)
                    for (int unsigned dc = 0; dc < 3; dc++)
                        acc += 32'(img[(r-2+dr)*W + (c-2+dc)]) * 32'(kern[dr*3+dc]);
                exp_q.push_back(acc[7:0]);
            end
        end
    endtask

    task automatic check_results(input string tag);
        logic [7:0] v;
        check({tag, "_count"}, 72'(res_q.size()), 72'(exp_q.size()));
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            v = 'x;
            if (i < res_q.size()) v = res_q[i];
            check($sformatf("%s[%0d]", tag, i), 72'(v), 72'(exp_q[i]));
        end
    endtask

    task automatic run_frame();
        int   cyc, pidx;
        bit   seen22, got_win, holding, accept, aborted;
        logic [7:0] held;
        cyc = 0; pidx = 0; seen22 = 0; got_win = 0; holding = 0; aborted = 0; held = '0;
        finished = 0; res_q.delete();
        done_cnt = 0; acc22_cyc = -1; first_res_cyc = -1; stall_chg = 0; pr_drop = 0;
        @(negedge clk);
        while (!finished && cyc < 400) begin
            bus.start_i     = (cyc == 0) || (cyc == start_pulse_cyc);
            bus.pix_valid_i = (pidx < NPIX) && ((vmode == 0) || ($urandom_range(0, 2) != 0));
            bus.pix_data_i  = (pidx < NPIX) ? img[pidx] : 8'h00;
            bus.res_ready_i = (rmode == 0) ? 1'b1 :
                              (rmode == 1) ? !(cyc >= 10 && cyc <= 20) :
                              1'($urandom_range(0, 1));
            #1;
            if (seen22 && !got_win) begin win22 = bus.win_o; got_win = 1; end
            if (bus.res_valid_o && first_res_cyc < 0) first_res_cyc = cyc;
            if (holding && bus.res_valid_o && bus.res_data_o !== held) stall_chg++;
            if (bus.busy_o && pidx < NPIX && !bus.pix_ready_o) pr_drop++;
            holding = bus.res_valid_o && !bus.res_ready_i;
            held    = bus.res_data_o;
            if (bus.res_valid_o && bus.res_ready_i) res_q.push_back(bus.res_data_o);
            if (bus.done_o) begin done_cnt++; finished = 1; end
            accept = bus.pix_valid_i && bus.pix_ready_o;
            if (accept && pidx == 2*W + 2) begin acc22_cyc = cyc; seen22 = 1; end
            @(posedge clk);
            if (accept) pidx++;
            if (abort_after > 0 && pidx == abort_after) begin aborted = 1; finished = 1; end
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 0; bus.pix_valid_i = 0; bus.res_ready_i = 0;
        if (aborted) begin
            rst = 1;
            @(negedge clk); @(negedge clk);
            rst = 0;
        end
        #1;
        busy_after = bus.busy_o;
    endtask

    initial begin
        win_t exp_w;
        int   exp_win [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

        rst = 1;
        bus.start_i = 0; bus.pix_valid_i = 0; bus.pix_data_i = '0; bus.res_ready_i = 0;
        bias = 0;
        for (int unsigned i = 0; i < 9; i++) kern[i] = 0;
        rmode = 0; vmode = 0; abort_after = 0; start_pulse_cyc = -1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",      72'(bus.busy_o),      72'(0));
        check("rst_done",      72'(bus.done_o),      72'(0));
        check("rst_pix_ready", 72'(bus.pix_ready_o), 72'(0));
        check("rst_res_valid", 72'(bus.res_valid_o), 72'(0));
        check("rst_win",       72'(bus.win_o),       72'(0));
        check("rst_res_data",  72'(bus.res_data_o),  72'(0));
        rst = 0;

        // Flat frame, box kernel: every result 9, full throughput
        for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'd1;
        for (int unsigned i = 0; i < 9; i++) kern[i] = 8'd1;
        run_frame();
        exp_q.delete();
        repeat (NRES) exp_q.push_back(8'd9);
        check_results("ones");
        check("ones_latency", 72'(first_res_cyc - acc22_cyc), 72'(2));
        check("ones_done",    72'(done_cnt),   72'(1));
        check("ones_idle",    72'(busy_after), 72'(0));
        check("ones_nodrop",  72'(pr_drop),    72'(0));

        // Ramp frame, centre-tap kernel: results are the window centres
        for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'(i);
        for (int unsigned i = 0; i < 9; i++) kern[i] = 8'd0;
        kern[4] = 8'd1;
        run_frame();
        exp_q.delete();
        exp_q.push_back(8'd6);  exp_q.push_back(8'd7);  exp_q.push_back(8'd8);
        exp_q.push_back(8'd11); exp_q.push_back(8'd12); exp_q.push_back(8'd13);
        check_results("ramp");
        for (int unsigned i = 0; i < 9; i++) exp_w[i] = 8'(exp_win[i]);
        check("ramp_win22", 72'(win22), 72'(exp_w));
        check("ramp_done",  72'(done_cnt), 72'(1));

        // Same ramp with result backpressure over cycles 10..20
        rmode = 1;
        run_frame();
        check_results("stall");
        check("stall_stable",  72'(stall_chg),   72'(0));
        check("stall_pr_drop", 72'(pr_drop > 0), 72'(1));
        check("stall_done",    72'(done_cnt),    72'(1));
        rmode = 0;

        // Saturated inputs: 9*255*255 truncates to 0x09
        for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'hff;
        for (int unsigned i = 0; i < 9; i++) kern[i] = 8'hff;
        run_frame();
        exp_q.delete();
        repeat (NRES) exp_q.push_back(8'h09);
        check_results("sat");
        check("sat_done", 72'(done_cnt), 72'(1));

        // Abort after 8 pixels, then a clean frame with a stray start in RUN
        for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'(i);
        for (int unsigned i = 0; i < 9; i++) kern[i] = 8'd0;
        kern[4] = 8'd1;
        abort_after = 8;
        run_frame();
        check("abort_done",      72'(done_cnt),        72'(0));
        check("abort_busy",      72'(busy_after),      72'(0));
        check("abort_res_valid", 72'(bus.res_valid_o), 72'(0));
        abort_after = 0;
        start_pulse_cyc = 5;
        run_frame();
        exp_q.delete();
        exp_q.push_back(8'd6);  exp_q.push_back(8'd7);  exp_q.push_back(8'd8);
        exp_q.push_back(8'd11); exp_q.push_back(8'd12); exp_q.push_back(8'd13);
        check_results("restart");
        check("restart_done", 72'(done_cnt), 72'(1));
        start_pulse_cyc = -1;

        // Random pixels, kernel, bias and handshakes against the direct model
        vmode = 1; rmode = 2;
        for (int unsigned f = 0; f < 3; f++) begin
            for (int unsigned i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
            for (int unsigned i = 0; i < 9; i++) kern[i] = 8'($urandom_range(0, 255));
            bias = 8'($urandom_range(0, 255));
            run_frame();
            build_expected();
            check_results($sformatf("rand%0d", f));
            check($sformatf("rand%0d_done", f), 72'(finished), 72'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
